// File: rtl/exibe_pkg.sv
// Shared definitions for the sequence display engine of the memory game.
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : address and word widths shared with the game datapath
//   T_ON_DEF / T_OFF_DEF    : default lit and dark intervals, in clock cycles
//   estado_t                : FSM state encoding, also exported on db_estado
//   largura_timer()         : timer width that holds max(t_on, t_off) - 1
package exibe_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned T_ON_DEF   = 10;
  localparam int unsigned T_OFF_DEF  = 10;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StCarrega = 4'd1,
    StCaptura = 4'd2,
    StAcende  = 4'd3,
    StApaga   = 4'd4,
    StFim     = 4'd5
  } estado_t;

  // Smallest width able to hold the largest terminal count (never below 1 bit).
  function automatic int unsigned largura_timer(int unsigned t_on, int unsigned t_off);
    int unsigned maior;
    maior = ((t_on > t_off) ? t_on : t_off) - 1;
    return (maior == 0) ? 1 : $clog2(maior + 1);
  endfunction

endpackage

// File: rtl/exibe_sequencia_contador_tempo.sv
// contador_tempo: modulo-N up counter with clear, enable and terminal-count flag.
// The terminal value (N-1) is an input so one instance can serve several intervals.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset, forces count to 0
//   limpa  in   synchronous clear, forces count to 0
//   conta  in   count enable
//   ultimo in   terminal value N-1; count wraps to 0 after it
//   fim    out  high while count equals ultimo
module contador_tempo #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa,
  input  logic         conta,
  input  logic [W-1:0] ultimo,
  output logic         fim
);

  logic [W-1:0] valor_q;

  always_comb begin
    fim = (valor_q == ultimo);
  end

  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      valor_q <= '0;
    end else if (conta) begin
      valor_q <= fim ? '0 : valor_q + 1'b1;
    end
  end

endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: shows the stored game sequence on the LEDs.
// On iniciar (sampled in IDLE) it walks the sequence ROM from address 0 up to the
// latched limite; each word is lit for T_ON cycles then dark for T_OFF cycles.
// pronto pulses for one cycle after the last dark interval.
// Ports:
//   clock, reset   clock and synchronous active-high reset
//   iniciar        start request, ignored outside IDLE
//   limite         index of last word to show, latched on start
//   mem_endereco   registered ROM address
//   mem_dado       registered ROM data, valid one cycle after the address
//   leds           displayed word, 0 when dark
//   ocupado        high in every state except IDLE
//   pronto         one-cycle end-of-sequence pulse
//   db_endereco    copy of mem_endereco
//   db_estado      state code
module exibe_sequencia
  import exibe_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned T_ON   = T_ON_DEF,
  parameter int unsigned T_OFF  = T_OFF_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  output logic [ADDR_W-1:0] mem_endereco,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [ADDR_W-1:0] db_endereco,
  output logic [3:0]        db_estado
);

  localparam int unsigned TW = largura_timer(T_ON, T_OFF);

  estado_t           estado_q;
  logic [ADDR_W-1:0] endereco_q;
  logic [ADDR_W-1:0] limite_q;
  logic [DATA_W-1:0] leds_q;
  logic              ocupado_q;
  logic              pronto_q;

  logic              tempo_limpa;
  logic              tempo_conta;
  logic [TW-1:0]     tempo_ultimo;
  logic              tempo_fim;

  // Timer is cleared in CAPTURA and wraps by itself at the end of ACENDE,
  // so it always enters APAGA at 0.
  always_comb begin
    tempo_limpa  = (estado_q == StCaptura);
    tempo_conta  = (estado_q == StAcende) || (estado_q == StApaga);
    tempo_ultimo = (estado_q == StAcende) ? TW'(T_ON - 1) : TW'(T_OFF - 1);
  end

  contador_tempo #(
    .W (TW)
  ) u_contador_tempo (
    .clock  (clock),
    .reset  (reset),
    .limpa  (tempo_limpa),
    .conta  (tempo_conta),
    .ultimo (tempo_ultimo),
    .fim    (tempo_fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= StIdle;
      endereco_q <= '0;
      limite_q   <= '0;
      leds_q     <= '0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        StIdle: begin
          if (iniciar) begin
            limite_q   <= limite;
            endereco_q <= '0;
            ocupado_q  <= 1'b1;
            estado_q   <= StCarrega;
          end
        end
        StCarrega: begin
          estado_q <= StCaptura;
        end
        StCaptura: begin
          leds_q   <= mem_dado;
          estado_q <= StAcende;
        end
        StAcende: begin
          if (tempo_fim) begin
            leds_q   <= '0;
            estado_q <= StApaga;
          end
        end
        StApaga: begin
          if (tempo_fim) begin
            // Compare before incrementing so the top address never wraps.
            if (endereco_q == limite_q) begin
              pronto_q <= 1'b1;
              estado_q <= StFim;
            end else begin
              endereco_q <= endereco_q + 1'b1;
              estado_q   <= StCarrega;
            end
          end
        end
        StFim: begin
          ocupado_q <= 1'b0;
          estado_q  <= StIdle;
        end
        default: begin
          leds_q    <= '0;
          ocupado_q <= 1'b0;
          estado_q  <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    mem_endereco = endereco_q;
    db_endereco  = endereco_q;
    leds         = leds_q;
    ocupado      = ocupado_q;
    pronto       = pronto_q;
    db_estado    = estado_q;
  end

endmodule

// File: tb/tb_exibe_sequencia.sv
module tb_exibe_sequencia;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] mem_endereco;
  logic [3:0] mem_dado;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_endereco;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  logic [3:0] rom [16];

  exibe_sequencia dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .limite       (limite),
    .mem_endereco (mem_endereco),
    .mem_dado     (mem_dado),
    .leds         (leds),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_endereco  (db_endereco),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered sequence ROM
  always @(posedge clock) mem_dado <= rom[mem_endereco];

  typedef struct {
    string       name;
    logic [3:0]  lim;
    logic [63:0] img;
    int          hold;
    int          pulse_at;
    logic [3:0]  lim_late;
    int          exp_pronto;
    int          exp_max_addr;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp, input string note);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d %s", name, act, exp, note);
    end
  endtask

  task automatic load_rom(input logic [63:0] img);
    for (int i = 0; i < 16; i++) rom[i] = img[4*i +: 4];
  endtask

  // Called right after a negedge with the engine idle. Cycle k is the interval
  // following edge E0+k, sampled at its negedge.
  task automatic run_trace(input vec_t v, output int n_pronto, output int first_pronto,
                           output int bad, output string msg, output int max_addr);
    int total;
    int w, r;
    logic [3:0] e_leds, e_addr, e_est;
    logic e_ocup, e_pr;
    total = 22 * (int'(v.lim) + 1);
    n_pronto = 0; first_pronto = -1; bad = 0; msg = ""; max_addr = 0;
    limite = v.lim;
    iniciar = 1'b1;
    @(posedge clock);
    for (int k = 0; k < v.exp_pronto + 4; k++) begin
      @(negedge clock);
      if (k == v.hold - 1) iniciar = 1'b0;
      if (v.pulse_at > 0 && k == v.pulse_at - 1) begin
        iniciar = 1'b1;
        limite  = v.lim_late;
      end
      if (v.pulse_at > 0 && k == v.pulse_at) iniciar = 1'b0;
      w = k / 22; r = k % 22;
      if (k < total) begin
        e_addr = 4'(w); e_ocup = 1'b1; e_pr = 1'b0;
        e_est  = (r == 0) ? 4'd1 : (r == 1) ? 4'd2 : (r < 12) ? 4'd3 : 4'd4;
        e_leds = (r >= 2 && r < 12) ? rom[w] : 4'd0;
      end else if (k == total) begin
        e_addr = v.lim; e_ocup = 1'b1; e_pr = 1'b1; e_est = 4'd5; e_leds = 4'd0;
      end else begin
        e_addr = v.lim; e_ocup = 1'b0; e_pr = 1'b0; e_est = 4'd0; e_leds = 4'd0;
      end
      if (pronto) begin
        n_pronto++;
        if (first_pronto < 0) first_pronto = k;
      end
      if (int'(mem_endereco) > max_addr) max_addr = int'(mem_endereco);
      if (leds !== e_leds || ocupado !== e_ocup || pronto !== e_pr || db_estado !== e_est ||
          mem_endereco !== e_addr || db_endereco !== e_addr) begin
        if (bad == 0)
          msg = $sformatf("(cycle %0d leds=%b/%b ocupado=%b/%b pronto=%b/%b estado=%0d/%0d addr=%0d/%0d db=%0d)",
                          k, leds, e_leds, ocupado, e_ocup, pronto, e_pr, db_estado, e_est,
                          mem_endereco, e_addr, db_endereco);
        bad++;
      end
    end
  endtask

  initial begin
    int n_pr, first_pr, bad, max_addr, cnt_pr, cnt_oc;
    string msg;
    int est [48];
    logic [3:0] led_hist [48];
    logic pr_hist [48];

    vecs[0] = '{"single",  4'd0,  64'h0000_0000_0000_0001, 1, 0,  4'd0, 22,  0};
    vecs[1] = '{"four",    4'd3,  64'h0000_0000_0000_8421, 1, 0,  4'd0, 88,  3};
    vecs[2] = '{"ignored", 4'd3,  64'h0000_0000_0000_8421, 5, 30, 4'd7, 88,  3};
    vecs[3] = '{"top",     4'd15, 64'h1248_8421_2481_4218, 1, 0,  4'd0, 352, 15};
    vecs[4] = '{"zero",    4'd2,  64'h0000_0000_0000_0402, 1, 0,  4'd0, 66,  2};

    reset = 1'b1; iniciar = 1'b0; limite = 4'd0;
    load_rom(64'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_leds", int'(leds), 0, "");
    chk("reset_ocupado", int'(ocupado), 0, "");
    chk("reset_pronto", int'(pronto), 0, "");
    chk("reset_addr", int'(mem_endereco), 0, "");
    chk("reset_estado", int'(db_estado), 0, "");
    reset = 1'b0;
    @(negedge clock);

    // Reset mid-ACENDE aborts with no pronto
    load_rom(64'h0000_0000_0000_8421);
    limite = 4'd3; iniciar = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      iniciar = 1'b0;
      if (k == 5) begin
        chk("pre_reset_estado", int'(db_estado), 3, "");
        chk("pre_reset_leds", int'(leds), 1, "");
        reset = 1'b1;
      end
    end
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_leds", int'(leds), 0, "");
    chk("midreset_ocupado", int'(ocupado), 0, "");
    chk("midreset_estado", int'(db_estado), 0, "");
    chk("midreset_addr", int'(mem_endereco), 0, "");
    cnt_pr = 0; cnt_oc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (pronto) cnt_pr++;
      if (ocupado) cnt_oc++;
    end
    chk("midreset_no_pronto", cnt_pr, 0, "");
    chk("midreset_stays_idle", cnt_oc, 0, "");

    for (int i = 0; i < 5; i++) begin
      load_rom(vecs[i].img);
      run_trace(vecs[i], n_pr, first_pr, bad, msg, max_addr);
      chk({vecs[i].name, "_trace"}, bad, 0, msg);
      chk({vecs[i].name, "_pronto_count"}, n_pr, 1, "");
      chk({vecs[i].name, "_pronto_cycle"}, first_pr, vecs[i].exp_pronto, "");
      chk({vecs[i].name, "_max_addr"}, max_addr, vecs[i].exp_max_addr, "");
    end

    // iniciar held through FIM restarts in the IDLE cycle after FIM
    load_rom(64'h0000_0000_0000_0001);
    limite = 4'd0; iniciar = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 48; k++) begin
      @(negedge clock);
      if (k == 24) iniciar = 1'b0;
      est[k] = int'(db_estado);
      led_hist[k] = leds;
      pr_hist[k] = pronto;
    end
    chk("restart_fim", est[22], 5, "");
    chk("restart_idle", est[23], 0, "");
    chk("restart_carrega", est[24], 1, "");
    chk("restart_leds", int'(led_hist[26]), 1, "");
    chk("restart_pronto2", int'(pr_hist[46]), 1, "");
    chk("restart_after", est[47], 0, "");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
